// File: rtl/cpu_defs.sv
// Shared CPU definitions: exception flag bundle, ExcCodes, CP0 register numbers
// and the packing of the Status/Cause words as software sees them.
package cpu_defs;

    typedef struct packed {
        logic adel_if;
        logic ri;
        logic ov;
        logic tr;
        logic sys;
        logic bp;
        logic adel_d;
        logic ades;
    } exc_flags_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } exc_state_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // BEV (bit 22) is hardwired to 1; IM at 15:8, EXL at 1, IE at 0.
    function automatic logic [31:0] status_word(input logic [7:0] im,
                                                input logic       exl,
                                                input logic       ie);
        return {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
    endfunction

    // BD at 31, TI at 30, IP at 15:8, ExcCode at 6:2.
    function automatic logic [31:0] cause_word(input logic       bd,
                                               input logic       ti,
                                               input logic [7:0] ip,
                                               input logic [4:0] code);
        return {bd, ti, 14'd0, ip, 1'b0, code, 2'd0};
    endfunction

endpackage

// File: rtl/exc_priority.sv
// Fixed-priority exception selector: picks one ExcCode and tells the commit
// stage where BadVAddr comes from, if anywhere.
module exc_priority
    import cpu_defs::*;
(
    input  exc_flags_t  i_flags,
    input  logic        i_int_pending,
    output logic        o_hit,
    output logic [4:0]  o_code,
    output logic        o_bad_pc,
    output logic        o_bad_mem
);

    // Priority chain; AdEL on fetch and on data share ExcCode 4.
    always_comb begin
        o_hit     = 1'b1;
        o_code    = EXC_INT;
        o_bad_pc  = 1'b0;
        o_bad_mem = 1'b0;
        if (i_int_pending) begin
            o_code = EXC_INT;
        end else if (i_flags.adel_if) begin
            o_code   = EXC_ADEL;
            o_bad_pc = 1'b1;
        end else if (i_flags.ri) begin
            o_code = EXC_RI;
        end else if (i_flags.ov) begin
            o_code = EXC_OV;
        end else if (i_flags.tr) begin
            o_code = EXC_TR;
        end else if (i_flags.sys) begin
            o_code = EXC_SYS;
        end else if (i_flags.bp) begin
            o_code = EXC_BP;
        end else if (i_flags.adel_d) begin
            o_code    = EXC_ADEL;
            o_bad_mem = 1'b1;
        end else if (i_flags.ades) begin
            o_code    = EXC_ADES;
            o_bad_mem = 1'b1;
        end else begin
            o_hit  = 1'b0;
            o_code = EXC_INT;
        end
    end

endmodule

// File: rtl/exception_commit.sv
// Exception commit unit at the MEM/WB boundary: owns the exception CP0 state,
// commits exceptions/ERET and issues a one-cycle registered flush + redirect.
module exception_commit
    import cpu_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        MEM_Valid,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_InDelaySlot,
    input  exc_flags_t  MEM_ExcFlags,
    input  logic [31:0] MEM_BadVAddr,
    input  logic        MEM_IsEret,
    input  logic        MEM_Cp0We,
    input  logic [4:0]  MEM_Cp0Addr,
    input  logic [31:0] MEM_Cp0WData,
    output logic [31:0] Cp0RData,
    input  logic [5:0]  HwInt,
    output logic        Exc_Flush,
    output logic [31:0] Exc_RedirectPC,
    output logic        Exc_Taken
);

    localparam logic [31:0] DIV_MAX = 32'(COUNT_DIV - 1);

    exc_state_t  r_state;
    exc_state_t  w_state_next;
    logic [31:0] r_redirect;
    logic        r_taken;

    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic [4:0]  r_cause_code;
    logic [1:0]  r_cause_ip_sw;
    logic [5:0]  r_hwint;
    logic        r_ti;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_div;

    logic [7:0]  w_ip;
    logic        w_int_pending;
    logic        w_hit;
    logic [4:0]  w_code;
    logic        w_bad_pc;
    logic        w_bad_mem;
    logic        w_idle;
    logic        w_accept;
    logic        w_exc;
    logic        w_eret;
    logic        w_mtc0;

    assign w_ip          = {r_hwint[5] | r_ti, r_hwint[4:0], r_cause_ip_sw};
    assign w_int_pending = r_status_ie & ~r_status_exl & (|(w_ip & r_status_im));
    assign w_idle        = (r_state == ST_IDLE);
    assign w_accept      = w_idle & MEM_Valid & (w_hit | MEM_IsEret);
    assign w_exc         = w_accept & w_hit;
    assign w_eret        = w_accept & ~w_hit;
    // A committed exception or ERET swallows the same-cycle MTC0.
    assign w_mtc0        = w_idle & MEM_Valid & MEM_Cp0We & ~w_accept;

    exc_priority u_prio (
        .i_flags       (MEM_ExcFlags),
        .i_int_pending (w_int_pending),
        .o_hit         (w_hit),
        .o_code        (w_code),
        .o_bad_pc      (w_bad_pc),
        .o_bad_mem     (w_bad_mem)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_state_next = w_accept ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from registered state only
    always_comb begin
        Exc_Flush      = 1'b0;
        Exc_Taken      = 1'b0;
        Exc_RedirectPC = 32'd0;
        if (r_state == ST_FLUSH) begin
            Exc_Flush      = 1'b1;
            Exc_Taken      = r_taken;
            Exc_RedirectPC = r_redirect;
        end else begin
            Exc_Flush      = 1'b0;
        end
    end

    // Latch the redirect target and kind on accept
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_redirect <= 32'd0;
            r_taken    <= 1'b0;
        end else if (w_accept) begin
            r_redirect <= w_exc ? EXC_VECTOR : r_epc;
            r_taken    <= w_exc;
        end else begin
            r_taken    <= 1'b0;
        end
    end

    // Timer: interrupt line sampling, Count divider, Compare and TI
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hwint   <= 6'd0;
            r_div     <= 32'd0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            r_hwint <= HwInt;
            if (r_div == DIV_MAX) begin
                r_div   <= 32'd0;
                r_count <= r_count + 32'd1;
            end else begin
                r_div   <= r_div + 32'd1;
            end
            if (w_mtc0 && MEM_Cp0Addr == CP0_COUNT) begin
                r_count <= MEM_Cp0WData;
            end
            if (w_mtc0 && MEM_Cp0Addr == CP0_COMPARE) begin
                r_compare <= MEM_Cp0WData;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti      <= 1'b1;
            end
        end
    end

    // Status/Cause/EPC/BadVAddr updates from commit, ERET and MTC0
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_status_im   <= 8'd0;
            r_status_exl  <= 1'b0;
            r_status_ie   <= 1'b0;
            r_cause_bd    <= 1'b0;
            r_cause_code  <= 5'd0;
            r_cause_ip_sw <= 2'd0;
            r_epc         <= 32'd0;
            r_badvaddr    <= 32'd0;
        end else if (w_exc) begin
            r_cause_code <= w_code;
            r_status_exl <= 1'b1;
            // Nested exceptions keep the original return point.
            if (!r_status_exl) begin
                r_epc      <= MEM_InDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
                r_cause_bd <= MEM_InDelaySlot;
            end
            if (w_bad_pc) begin
                r_badvaddr <= MEM_PC;
            end else if (w_bad_mem) begin
                r_badvaddr <= MEM_BadVAddr;
            end
        end else if (w_eret) begin
            r_status_exl <= 1'b0;
        end else if (w_mtc0) begin
            case (MEM_Cp0Addr)
                CP0_STATUS: begin
                    r_status_im  <= MEM_Cp0WData[15:8];
                    r_status_exl <= MEM_Cp0WData[1];
                    r_status_ie  <= MEM_Cp0WData[0];
                end
                CP0_CAUSE: r_cause_ip_sw <= MEM_Cp0WData[9:8];
                CP0_EPC:   r_epc         <= MEM_Cp0WData;
                default:   r_epc         <= r_epc;
            endcase
        end
    end

    // MFC0 read port, pre-write values
    always_comb begin
        Cp0RData = 32'd0;
        case (MEM_Cp0Addr)
            CP0_BADVADDR: Cp0RData = r_badvaddr;
            CP0_COUNT:    Cp0RData = r_count;
            CP0_COMPARE:  Cp0RData = r_compare;
            CP0_STATUS:   Cp0RData = status_word(r_status_im, r_status_exl, r_status_ie);
            CP0_CAUSE:    Cp0RData = cause_word(r_cause_bd, r_ti, w_ip, r_cause_code);
            CP0_EPC:      Cp0RData = r_epc;
            default:      Cp0RData = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_exception_commit.sv
// Directed bench for exception_commit: a vector table of single-instruction
// commits plus hand-written sequences for flush shadow, reset and the timer.
module tb_exception_commit;
    import cpu_defs::*;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        MEM_Valid = 1'b0;
    logic [31:0] MEM_PC = 32'd0;
    logic        MEM_InDelaySlot = 1'b0;
    exc_flags_t  MEM_ExcFlags = '0;
    logic [31:0] MEM_BadVAddr = 32'd0;
    logic        MEM_IsEret = 1'b0;
    logic        MEM_Cp0We = 1'b0;
    logic [4:0]  MEM_Cp0Addr = 5'd0;
    logic [31:0] MEM_Cp0WData = 32'd0;
    logic [31:0] Cp0RData;
    logic [5:0]  HwInt = 6'd0;
    logic        Exc_Flush;
    logic [31:0] Exc_RedirectPC;
    logic        Exc_Taken;

    int checks = 0;
    int failures = 0;

    exception_commit #(.EXC_VECTOR(VEC), .COUNT_DIV(2)) dut (
        .clk(clk), .resetn(resetn), .MEM_Valid(MEM_Valid), .MEM_PC(MEM_PC),
        .MEM_InDelaySlot(MEM_InDelaySlot), .MEM_ExcFlags(MEM_ExcFlags),
        .MEM_BadVAddr(MEM_BadVAddr), .MEM_IsEret(MEM_IsEret), .MEM_Cp0We(MEM_Cp0We),
        .MEM_Cp0Addr(MEM_Cp0Addr), .MEM_Cp0WData(MEM_Cp0WData), .Cp0RData(Cp0RData),
        .HwInt(HwInt), .Exc_Flush(Exc_Flush), .Exc_RedirectPC(Exc_RedirectPC),
        .Exc_Taken(Exc_Taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] status;
        logic [31:0] epc;
        logic [5:0]  hwint;
        logic [31:0] pc;
        logic        ds;
        logic [7:0]  flags;
        logic        eret;
        logic [31:0] badva;
        logic        e_flush;
        logic        e_taken;
        logic [31:0] e_redir;
        logic [31:0] e_epc;
        logic [4:0]  e_code;
        logic        e_bd;
        logic        e_exl;
        logic [31:0] e_badva;
    } vec_t;

    vec_t vt[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MEM_Valid = 1'b0; MEM_ExcFlags = '0; MEM_IsEret = 1'b0; MEM_Cp0We = 1'b0;
        MEM_InDelaySlot = 1'b0; MEM_PC = 32'd0; MEM_BadVAddr = 32'd0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        MEM_Valid = 1'b1; MEM_Cp0We = 1'b1; MEM_Cp0Addr = addr; MEM_Cp0WData = data;
        tick();
        idle_inputs();
    endtask

    task automatic mfc0(input logic [4:0] addr, output logic [31:0] data);
        MEM_Cp0Addr = addr;
        #1;
        data = Cp0RData;
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] st, input logic [31:0] ep,
                                input logic [5:0] hw, input logic [31:0] pc, input logic ds,
                                input logic [7:0] fl, input logic er, input logic [31:0] bva,
                                input logic ef, input logic et, input logic [31:0] erd,
                                input logic [31:0] eep, input logic [4:0] ec, input logic ebd,
                                input logic eexl, input logic [31:0] ebva);
        vec_t r;
        r.valid = v; r.status = st; r.epc = ep; r.hwint = hw; r.pc = pc; r.ds = ds;
        r.flags = fl; r.eret = er; r.badva = bva; r.e_flush = ef; r.e_taken = et;
        r.e_redir = erd; r.e_epc = eep; r.e_code = ec; r.e_bd = ebd; r.e_exl = eexl;
        r.e_badva = ebva;
        return r;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] c0;
        logic [31:0] c1;
        logic [31:0] cmp;
        logic        seen;

        // flags order {AdEL_if, RI, Ov, Trap, Sys, Bp, AdEL_d, AdES}
        vt[0]  = mk(1'b1, 32'h0, 32'h0, 6'd0, 32'h8000_1000, 1'b0, 8'b0001_0000, 1'b0, 32'h0,
                    1'b1, 1'b1, VEC, 32'h8000_1000, 5'd13, 1'b0, 1'b1, 32'h0);
        vt[1]  = mk(1'b1, 32'h0, 32'h0, 6'd0, 32'h8000_2004, 1'b1, 8'b0010_0000, 1'b0, 32'h0,
                    1'b1, 1'b1, VEC, 32'h8000_2000, 5'd12, 1'b1, 1'b1, 32'h0);
        vt[2]  = mk(1'b1, 32'h0, 32'h0, 6'd0, 32'h8000_4000, 1'b0, 8'b0101_1000, 1'b0, 32'h0,
                    1'b1, 1'b1, VEC, 32'h8000_4000, 5'd10, 1'b0, 1'b1, 32'h0);
        vt[3]  = mk(1'b1, 32'h2, 32'h8000_5550, 6'd0, 32'h8000_6000, 1'b1, 8'b0000_1000, 1'b0, 32'h0,
                    1'b1, 1'b1, VEC, 32'h8000_5550, 5'd8, 1'b0, 1'b1, 32'h0);
        vt[4]  = mk(1'b1, 32'h401, 32'h0, 6'd1, 32'h8000_7000, 1'b0, 8'b0, 1'b0, 32'h0,
                    1'b1, 1'b1, VEC, 32'h8000_7000, 5'd0, 1'b0, 1'b1, 32'h0);
        vt[5]  = mk(1'b1, 32'h403, 32'h8000_1234, 6'd1, 32'h8000_7100, 1'b0, 8'b0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h8000_1234, 5'd0, 1'b0, 1'b1, 32'h0);
        vt[6]  = mk(1'b1, 32'h2, 32'h8000_3000, 6'd0, 32'h8000_7200, 1'b0, 8'b0, 1'b1, 32'h0,
                    1'b1, 1'b0, 32'h8000_3000, 32'h8000_3000, 5'd0, 1'b0, 1'b0, 32'h0);
        vt[7]  = mk(1'b1, 32'h0, 32'h0, 6'd0, 32'h8000_8000, 1'b0, 8'b1000_0010, 1'b0, 32'h1234_5678,
                    1'b1, 1'b1, VEC, 32'h8000_8000, 5'd4, 1'b0, 1'b1, 32'h8000_8000);
        vt[8]  = mk(1'b1, 32'h0, 32'h0, 6'd0, 32'h8000_9000, 1'b1, 8'b0000_0001, 1'b0, 32'h0000_0BAD,
                    1'b1, 1'b1, VEC, 32'h8000_8FFC, 5'd5, 1'b1, 1'b1, 32'h0000_0BAD);
        vt[9]  = mk(1'b1, 32'h2, 32'h8000_3000, 6'd0, 32'h8000_900C, 1'b0, 8'b0000_0100, 1'b1, 32'h0,
                    1'b1, 1'b1, VEC, 32'h8000_3000, 5'd9, 1'b1, 1'b1, 32'h0000_0BAD);
        vt[10] = mk(1'b0, 32'h0, 32'h8000_0010, 6'd0, 32'h8000_A000, 1'b0, 8'b0001_0000, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h8000_0010, 5'd9, 1'b1, 1'b0, 32'h0000_0BAD);
        vt[11] = mk(1'b1, 32'h401, 32'h0, 6'd1, 32'h8000_A000, 1'b0, 8'b1000_0000, 1'b0, 32'h0,
                    1'b1, 1'b1, VEC, 32'h8000_A000, 5'd0, 1'b0, 1'b1, 32'h0000_0BAD);
        vt[12] = mk(1'b1, 32'h0, 32'h0, 6'd0, 32'h8000_C000, 1'b0, 8'b0011_1100, 1'b0, 32'h0,
                    1'b1, 1'b1, VEC, 32'h8000_C000, 5'd12, 1'b0, 1'b1, 32'h0000_0BAD);
        vt[13] = mk(1'b1, 32'h0, 32'h0, 6'd0, 32'h8000_C100, 1'b0, 8'b0001_0110, 1'b0, 32'h2222_0000,
                    1'b1, 1'b1, VEC, 32'h8000_C100, 5'd13, 1'b0, 1'b1, 32'h0000_0BAD);
        vt[14] = mk(1'b1, 32'h0, 32'h0, 6'd0, 32'h8000_C200, 1'b0, 8'b0000_0111, 1'b0, 32'h3333_0000,
                    1'b1, 1'b1, VEC, 32'h8000_C200, 5'd9, 1'b0, 1'b1, 32'h0000_0BAD);
        vt[15] = mk(1'b1, 32'h0, 32'h0, 6'd0, 32'h8000_C300, 1'b1, 8'b0000_0011, 1'b0, 32'h0000_1110,
                    1'b1, 1'b1, VEC, 32'h8000_C2FC, 5'd4, 1'b1, 1'b1, 32'h0000_1110);

        // Reset values, sampled while reset is still held
        tick(); tick();
        chk("rst_flush", {31'd0, Exc_Flush}, 32'd0);
        chk("rst_taken", {31'd0, Exc_Taken}, 32'd0);
        chk("rst_redir", Exc_RedirectPC, 32'd0);
        mfc0(CP0_STATUS, rd);   chk("rst_status", rd, 32'h0040_0000);
        mfc0(CP0_CAUSE, rd);    chk("rst_cause", rd, 32'd0);
        mfc0(CP0_EPC, rd);      chk("rst_epc", rd, 32'd0);
        mfc0(CP0_COUNT, rd);    chk("rst_count", rd, 32'd0);
        mfc0(5'd3, rd);         chk("unimpl_reg", rd, 32'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            HwInt = vt[i].hwint;
            mtc0(CP0_EPC, vt[i].epc);
            mtc0(CP0_STATUS, vt[i].status);
            MEM_Valid = vt[i].valid; MEM_PC = vt[i].pc; MEM_InDelaySlot = vt[i].ds;
            MEM_ExcFlags = exc_flags_t'(vt[i].flags); MEM_IsEret = vt[i].eret;
            MEM_BadVAddr = vt[i].badva;
            tick();
            idle_inputs();
            chk($sformatf("v%0d_flush", i), {31'd0, Exc_Flush}, {31'd0, vt[i].e_flush});
            chk($sformatf("v%0d_taken", i), {31'd0, Exc_Taken}, {31'd0, vt[i].e_taken});
            chk($sformatf("v%0d_redir", i), Exc_RedirectPC, vt[i].e_redir);
            mfc0(CP0_EPC, rd);      chk($sformatf("v%0d_epc", i), rd, vt[i].e_epc);
            mfc0(CP0_CAUSE, rd);
            chk($sformatf("v%0d_code", i), {27'd0, rd[6:2]}, {27'd0, vt[i].e_code});
            chk($sformatf("v%0d_bd", i), {31'd0, rd[31]}, {31'd0, vt[i].e_bd});
            mfc0(CP0_STATUS, rd);   chk($sformatf("v%0d_exl", i), {31'd0, rd[1]}, {31'd0, vt[i].e_exl});
            mfc0(CP0_BADVADDR, rd); chk($sformatf("v%0d_badva", i), rd, vt[i].e_badva);
            HwInt = 6'd0;
            tick();
        end

        // Flush shadow: Trap then Sys+MTC0 in the FLUSH cycle
        mtc0(CP0_STATUS, 32'h0);
        MEM_Valid = 1'b1; MEM_PC = 32'h8000_E000; MEM_ExcFlags = exc_flags_t'(8'b0001_0000);
        tick();
        chk("shadow_flush1", {31'd0, Exc_Flush}, 32'd1);
        MEM_PC = 32'h8000_E100; MEM_ExcFlags = exc_flags_t'(8'b0000_1000);
        MEM_Cp0We = 1'b1; MEM_Cp0Addr = CP0_EPC; MEM_Cp0WData = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        chk("shadow_flush2", {31'd0, Exc_Flush}, 32'd0);
        chk("shadow_taken2", {31'd0, Exc_Taken}, 32'd0);
        mfc0(CP0_EPC, rd);   chk("shadow_epc", rd, 32'h8000_E000);
        mfc0(CP0_CAUSE, rd); chk("shadow_code", {27'd0, rd[6:2]}, 32'd13);
        tick();

        // MTC0 EPC alongside Bp, nested (EXL=1): write is discarded
        mtc0(CP0_STATUS, 32'h2);
        mtc0(CP0_EPC, 32'h8000_0400);
        MEM_Valid = 1'b1; MEM_PC = 32'h8000_F000; MEM_ExcFlags = exc_flags_t'(8'b0000_0100);
        MEM_Cp0We = 1'b1; MEM_Cp0Addr = CP0_EPC; MEM_Cp0WData = 32'h1111_1110;
        tick();
        idle_inputs();
        chk("mtcbp_flush", {31'd0, Exc_Flush}, 32'd1);
        mfc0(CP0_EPC, rd);   chk("mtcbp_epc", rd, 32'h8000_0400);
        mfc0(CP0_CAUSE, rd); chk("mtcbp_code", {27'd0, rd[6:2]}, 32'd9);
        tick();

        // Reset during FLUSH drops the redirect
        mtc0(CP0_STATUS, 32'h0);
        MEM_Valid = 1'b1; MEM_PC = 32'h8001_0000; MEM_ExcFlags = exc_flags_t'(8'b0001_0000);
        tick();
        idle_inputs();
        chk("rstfl_flush_pre", {31'd0, Exc_Flush}, 32'd1);
        resetn = 1'b0;
        tick();
        chk("rstfl_flush", {31'd0, Exc_Flush}, 32'd0);
        chk("rstfl_redir", Exc_RedirectPC, 32'd0);
        chk("rstfl_taken", {31'd0, Exc_Taken}, 32'd0);
        mfc0(CP0_STATUS, rd); chk("rstfl_status", rd, 32'h0040_0000);
        resetn = 1'b1;
        tick();

        // Count runs at half the clock rate
        mfc0(CP0_COUNT, c0);
        repeat (10) tick();
        mfc0(CP0_COUNT, c1);
        chk("count_rate", c1 - c0, 32'd5);

        // Count wraps to zero
        mtc0(CP0_COUNT, 32'hFFFF_FFFF);
        tick(); tick();
        mfc0(CP0_COUNT, rd); chk("count_wrap", rd, 32'd0);

        // Compare match raises IP[7]; Compare write clears it
        mfc0(CP0_COUNT, c0);
        cmp = c0 + 32'd10;
        mtc0(CP0_COMPARE, cmp);
        mfc0(CP0_CAUSE, rd); chk("ti_clear0", {31'd0, rd[15]}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            mfc0(CP0_CAUSE, rd);
            seen = rd[15];
        end
        chk("ti_set", {31'd0, seen}, 32'd1);
        mfc0(CP0_COUNT, rd);
        chk("ti_when", {31'd0, ((rd - cmp) <= 32'd1)}, 32'd1);
        mfc0(CP0_COUNT, c1);
        mtc0(CP0_COMPARE, c1 + 32'd1000);
        mfc0(CP0_CAUSE, rd); chk("ti_clear1", {31'd0, rd[15]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
